// File: rtl/riscv_pkg.sv
// Shared RV32I execute-stage types: ALU operation and branch funct3 encodings.
package riscv_pkg;

  localparam int XLEN = 32;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_SLL   = 4'd2,
    ALU_SLT   = 4'd3,
    ALU_SLTU  = 4'd4,
    ALU_XOR   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_OR    = 4'd8,
    ALU_AND   = 4'd9,
    ALU_PASSB = 4'd10
  } alu_op_e;

  typedef enum logic [2:0] {
    BR_BEQ  = 3'b000,
    BR_BNE  = 3'b001,
    BR_BLT  = 3'b100,
    BR_BGE  = 3'b101,
    BR_BLTU = 3'b110,
    BR_BGEU = 3'b111
  } br_funct3_e;

endpackage

// File: rtl/alu_compare_unit_branch_compare.sv
// Branch-condition comparator: evaluates the B-type funct3 condition on forwarded rs1/rs2.
module branch_compare #(
  parameter int XLEN = riscv_pkg::XLEN
) (
  input  logic [XLEN-1:0] cmp_in1,
  input  logic [XLEN-1:0] cmp_in2,
  input  logic [2:0]      funct3,
  output logic            cond
);
  import riscv_pkg::*;

  logic w_eq;
  logic w_lt;
  logic w_ltu;

  assign w_eq  = (cmp_in1 == cmp_in2);
  assign w_lt  = ($signed(cmp_in1) < $signed(cmp_in2));
  assign w_ltu = (cmp_in1 < cmp_in2);

  // Undefined funct3 codes (010, 011) never take the branch.
  always_comb begin
    cond = 1'b0;
    case (funct3)
      BR_BEQ:  cond = w_eq;
      BR_BNE:  cond = ~w_eq;
      BR_BLT:  cond = w_lt;
      BR_BGE:  cond = ~w_lt;
      BR_BLTU: cond = w_ltu;
      BR_BGEU: cond = ~w_ltu;
      default: cond = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_compare_unit.sv
// Execute-stage ALU plus branch comparator, with combinational outputs for pc_exec and
// an optional registered copy for the pipeline register.
module alu_compare_unit #(
  parameter int XLEN = riscv_pkg::XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] in1,
  input  logic [XLEN-1:0] in2,
  input  logic [3:0]      alu_op,
  input  logic [XLEN-1:0] cmp_in1,
  input  logic [XLEN-1:0] cmp_in2,
  input  logic [2:0]      funct3,
  input  logic            valid_in,
  output logic [XLEN-1:0] result,
  output logic            cond,
  output logic [XLEN-1:0] result_q,
  output logic            cond_q,
  output logic            valid_q
);
  import riscv_pkg::*;

  logic [4:0]      w_shamt;
  logic [XLEN-1:0] w_result;
  logic            w_cond;
  logic [XLEN-1:0] r_result;
  logic            r_cond;
  logic            r_valid;

  // Only the low five bits of operand B form the shift amount.
  assign w_shamt = in2[4:0];

  always_comb begin
    w_result = '0;
    case (alu_op)
      ALU_ADD:   w_result = in1 + in2;
      ALU_SUB:   w_result = in1 - in2;
      ALU_SLL:   w_result = in1 << w_shamt;
      ALU_SLT:   w_result = {{(XLEN-1){1'b0}}, ($signed(in1) < $signed(in2))};
      ALU_SLTU:  w_result = {{(XLEN-1){1'b0}}, (in1 < in2)};
      ALU_XOR:   w_result = in1 ^ in2;
      ALU_SRL:   w_result = in1 >> w_shamt;
      ALU_SRA:   w_result = $unsigned($signed(in1) >>> w_shamt);
      ALU_OR:    w_result = in1 | in2;
      ALU_AND:   w_result = in1 & in2;
      ALU_PASSB: w_result = in2;
      default:   w_result = '0;
    endcase
  end

  branch_compare #(.XLEN(XLEN)) u_branch_compare (
    .cmp_in1 (cmp_in1),
    .cmp_in2 (cmp_in2),
    .funct3  (funct3),
    .cond    (w_cond)
  );

  assign result = w_result;
  assign cond   = w_cond;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_result <= '0;
      r_cond   <= 1'b0;
      r_valid  <= 1'b0;
    end else begin
      r_valid <= valid_in;
      if (valid_in) begin
        r_result <= w_result;
        r_cond   <= w_cond;
      end
    end
  end

  assign result_q = r_result;
  assign cond_q   = r_cond;
  assign valid_q  = r_valid;

endmodule

// File: tb/tb_alu_compare_unit.sv
// Directed and randomized checks of alu_compare_unit against an arithmetic reference model.
module tb_alu_compare_unit;

  logic        clk;
  logic        rst;
  logic [31:0] in1, in2, cmp_in1, cmp_in2;
  logic [3:0]  alu_op;
  logic [2:0]  funct3;
  logic        valid_in;
  logic [31:0] result, result_q;
  logic        cond, cond_q, valid_q;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [31:0] exp_rq;
  logic        exp_cq;
  logic        exp_vq;

  alu_compare_unit #(.XLEN(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .in1      (in1),
    .in2      (in2),
    .alu_op   (alu_op),
    .cmp_in1  (cmp_in1),
    .cmp_in2  (cmp_in2),
    .funct3   (funct3),
    .valid_in (valid_in),
    .result   (result),
    .cond     (cond),
    .result_q (result_q),
    .cond_q   (cond_q),
    .valid_q  (valid_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam longint M32 = 64'h1_0000_0000;

  function automatic longint pow2(input int sh);
    longint p = 1;
    for (int k = 0; k < sh; k++) p = p * 2;
    return p;
  endfunction

  function automatic logic [31:0] ref_alu(input int op, input logic [31:0] a, input logic [31:0] b);
    longint ua = longint'(a);
    longint ub = longint'(b);
    longint sa = longint'(int'(a));
    longint sb = longint'(int'(b));
    longint p  = pow2(int'(b) & 31);
    longint q;
    case (op)
      0:  return 32'((ua + ub) % M32);
      1:  return 32'((ua - ub + M32) % M32);
      2:  return 32'((ua * p) % M32);
      3:  return (sa < sb) ? 32'd1 : 32'd0;
      4:  return (ua < ub) ? 32'd1 : 32'd0;
      5:  return a ^ b;
      6:  return 32'(ua / p);
      7: begin
        q = sa / p;
        if (sa < 0 && (sa % p) != 0) q = q - 1;
        return 32'((q + M32) % M32);
      end
      8:  return a | b;
      9:  return a & b;
      10: return b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic ref_cond(input int f3, input logic [31:0] a, input logic [31:0] b);
    longint sa = longint'(int'(a));
    longint sb = longint'(int'(b));
    longint ua = longint'(a);
    longint ub = longint'(b);
    case (f3)
      0: return ua == ub;
      1: return ua != ub;
      4: return sa < sb;
      5: return sa >= sb;
      6: return ua < ub;
      7: return ua >= ub;
      default: return 1'b0;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic alu_case(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] expv);
    alu_op = op; in1 = a; in2 = b;
    #1;
    check(tag, result, expv);
  endtask

  task automatic br_case(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic expv);
    funct3 = f3; cmp_in1 = a; cmp_in2 = b;
    #1;
    check(tag, {31'd0, cond}, {31'd0, expv});
  endtask

  logic [31:0] pool [8];

  function automatic logic [31:0] pick();
    if ($urandom_range(0, 2) == 0) return pool[$urandom_range(0, 7)];
    return $urandom;
  endfunction

  initial begin
    pool[0] = 32'h0000_0000; pool[1] = 32'h0000_0001; pool[2] = 32'hFFFF_FFFF;
    pool[3] = 32'h7FFF_FFFF; pool[4] = 32'h8000_0000; pool[5] = 32'h0000_001F;
    pool[6] = 32'h0000_0020; pool[7] = 32'hFFFF_FFFE;

    rst = 1'b1; valid_in = 1'b0;
    in1 = 32'd0; in2 = 32'd0; alu_op = 4'd0;
    cmp_in1 = 32'd0; cmp_in2 = 32'd0; funct3 = 3'd0;
    #2;
    check("reset_result_q", result_q, 32'd0);
    check("reset_cond_q", {31'd0, cond_q}, 32'd0);
    check("reset_valid_q", {31'd0, valid_q}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    alu_case("add_overflow", 4'd0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000);
    alu_case("sub_wrap", 4'd1, 32'h0, 32'h1, 32'hFFFF_FFFF);
    alu_case("passb", 4'd10, 32'hDEAD_BEEF, 32'h1234_5000, 32'h1234_5000);
    alu_case("sra_31", 4'd7, 32'h8000_0000, 32'h0000_003F, 32'hFFFF_FFFF);
    alu_case("srl_31", 4'd6, 32'h8000_0000, 32'h0000_003F, 32'h0000_0001);
    alu_case("sll_mask", 4'd2, 32'h0000_0001, 32'h0000_0021, 32'h0000_0002);
    alu_case("shift_zero", 4'd7, 32'h8765_4321, 32'h0000_0020, 32'h8765_4321);
    alu_case("slt_neg", 4'd3, 32'hFFFF_FFFF, 32'h0, 32'h1);
    alu_case("sltu_big", 4'd4, 32'hFFFF_FFFF, 32'h0, 32'h0);
    alu_case("and", 4'd9, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0);
    alu_case("or", 4'd8, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFFF0_FFF0);
    alu_case("xor", 4'd5, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFF00_FF00);
    alu_case("reserved_11", 4'd11, 32'h1234_5678, 32'h1, 32'h0);
    alu_case("reserved_15", 4'd15, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0);

    br_case("blt", 3'b100, 32'hFFFF_FFFE, 32'h1, 1'b1);
    br_case("bge", 3'b101, 32'hFFFF_FFFE, 32'h1, 1'b0);
    br_case("bltu", 3'b110, 32'hFFFF_FFFE, 32'h1, 1'b0);
    br_case("bgeu", 3'b111, 32'hFFFF_FFFE, 32'h1, 1'b1);
    br_case("beq_ne", 3'b000, 32'hFFFF_FFFE, 32'h1, 1'b0);
    br_case("bne_ne", 3'b001, 32'hFFFF_FFFE, 32'h1, 1'b1);
    br_case("beq_eq", 3'b000, 32'd5, 32'd5, 1'b1);
    br_case("bge_eq", 3'b101, 32'd5, 32'd5, 1'b1);
    br_case("bgeu_eq", 3'b111, 32'd5, 32'd5, 1'b1);
    br_case("blt_eq", 3'b100, 32'd5, 32'd5, 1'b0);
    br_case("bltu_eq", 3'b110, 32'd5, 32'd5, 1'b0);
    br_case("f3_010", 3'b010, 32'd5, 32'd5, 1'b0);
    br_case("f3_011", 3'b011, 32'd1, 32'd2, 1'b0);

    // Registered stage: capture, then hold with valid_in low.
    @(negedge clk);
    alu_op = 4'd0; in1 = 32'd3; in2 = 32'd4; valid_in = 1'b1;
    funct3 = 3'b000; cmp_in1 = 32'd9; cmp_in2 = 32'd9;
    @(posedge clk); #1;
    check("reg_capture", result_q, 32'd7);
    check("reg_capture_cond", {31'd0, cond_q}, 32'd1);
    check("reg_capture_valid", {31'd0, valid_q}, 32'd1);
    @(negedge clk);
    in1 = 32'd100; in2 = 32'd200; cmp_in2 = 32'd8; valid_in = 1'b0;
    @(posedge clk); #1;
    check("reg_hold", result_q, 32'd7);
    check("reg_hold_cond", {31'd0, cond_q}, 32'd1);
    check("reg_hold_valid", {31'd0, valid_q}, 32'd0);

    // Asynchronous reset between edges.
    @(negedge clk);
    in1 = 32'd3; in2 = 32'd4; valid_in = 1'b1;
    @(posedge clk); #1;
    check("pre_rst_capture", result_q, 32'd7);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_result_q", result_q, 32'd0);
    check("async_rst_cond_q", {31'd0, cond_q}, 32'd0);
    check("async_rst_valid_q", {31'd0, valid_q}, 32'd0);
    in1 = 32'd10;
    #1;
    check("comb_during_rst", result, 32'd14);
    @(negedge clk);
    rst = 1'b0;
    exp_rq = 32'd0; exp_cq = 1'b0; exp_vq = 1'b0;

    // Randomized traffic against the reference model.
    for (int i = 0; i < 300; i++) begin
      logic [31:0] e_res;
      logic        e_cond;
      @(negedge clk);
      alu_op   = 4'($urandom_range(0, 15));
      in1      = pick();
      in2      = pick();
      funct3   = 3'($urandom_range(0, 7));
      cmp_in1  = pick();
      cmp_in2  = ($urandom_range(0, 3) == 0) ? cmp_in1 : pick();
      valid_in = 1'($urandom_range(0, 1));
      e_res  = ref_alu(int'(alu_op), in1, in2);
      e_cond = ref_cond(int'(funct3), cmp_in1, cmp_in2);
      #1;
      check($sformatf("rnd_result op=%0d a=%h b=%h", alu_op, in1, in2), result, e_res);
      check($sformatf("rnd_cond f3=%0d a=%h b=%h", funct3, cmp_in1, cmp_in2),
            {31'd0, cond}, {31'd0, e_cond});
      if (valid_in) begin
        exp_rq = e_res;
        exp_cq = e_cond;
      end
      exp_vq = valid_in;
      @(posedge clk); #1;
      check("rnd_result_q", result_q, exp_rq);
      check("rnd_cond_q", {31'd0, cond_q}, {31'd0, exp_cq});
      check("rnd_valid_q", {31'd0, valid_q}, {31'd0, exp_vq});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_compare_unit.md
Name: alu_compare_unit

Overview:
- Execute-stage datapath core of the RV32I pipeline: a 32-bit integer ALU plus a branch-condition comparator.
- The execute stage muxes forwarded operands in and uses `result` combinationally as the branch/jump target (pc_exec).
- The execute stage uses `cond` for the pc_reset decision.
- A registered copy of both outputs is provided for pipeline-register use and debug.

Parameters:
- XLEN, 32, datapath width.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-high reset.
- in1  input  XLEN  ALU operand A (rs1 or PC).
- in2  input  XLEN  ALU operand B (rs2 or sign-extended immediate).
- alu_op  input  4  ALU operation, alu_op_e.
- cmp_in1  input  XLEN  comparator operand (forwarded rs1).
- cmp_in2  input  XLEN  comparator operand (forwarded rs2).
- funct3  input  3  branch type (RISC-V B-type funct3).
- valid_in  input  1  capture enable for the registered stage.
- result  output  XLEN  combinational ALU result.
- cond  output  1  combinational branch condition.
- result_q  output  XLEN  registered result.
- cond_q  output  1  registered cond.
- valid_q  output  1  registered valid_in.

Behaviour:
- ALU is combinational, zero latency, and must settle within the same cycle because pc_exec depends on it.
- ALU ops, alu_op_e encoding:
  - 0 ADD: in1 + in2, mod 2^32.
  - 1 SUB: in1 - in2, mod 2^32.
  - 2 SLL: in1 << in2[4:0].
  - 3 SLT: signed compare, 1 if in1 < in2, zero-extended.
  - 4 SLTU: unsigned compare, same form.
  - 5 XOR.
  - 6 SRL: logical shift right by in2[4:0].
  - 7 SRA: arithmetic shift right by in2[4:0], sign-filled.
  - 8 OR.
  - 9 AND.
  - 10 PASSB: result = in2 (LUI).
  - 11–15 reserved: result = 0.
- Shift amounts use only bits [4:0]; upper bits are ignored. No overflow or carry flags.
- Comparator is combinational, with funct3:
  - 000 BEQ: cond = 1 if equal.
  - 001 BNE: cond = 1 if not equal.
  - 100 BLT: signed less-than.
  - 101 BGE: signed greater-or-equal.
  - 110 BLTU: unsigned less-than.
  - 111 BGEU: unsigned greater-or-equal.
  - 010, 011: cond = 0.
- cond is computed for every funct3 regardless of instruction type; the consumer gates it with use_pc, v_de and flush.
- Registered stage:
  - On posedge clk with valid_in = 1: result_q ← result, cond_q ← cond.
  - On posedge clk with valid_in = 0: result_q and cond_q hold.
  - valid_q ← valid_in every cycle.
- Reset:
  - rst asserts asynchronously and forces result_q = 0, cond_q = 0, valid_q = 0 immediately.
  - Release is sampled at the next posedge.
  - Combinational outputs are unaffected by rst.
- Boundaries:
  - 0x7FFFFFFF + 1 = 0x80000000.
  - 0 - 1 = 0xFFFFFFFF.
  - SRA of 0x80000000 by 31 = 0xFFFFFFFF.
  - Shift by 0 = identity.
  - SLT(0xFFFFFFFF, 0) = 1; SLTU(0xFFFFFFFF, 0) = 0.
  - Equal operands: BGE = 1, BGEU = 1, BLT = 0, BLTU = 0.

Decomposition:
- Shared package riscv_pkg holds:
  - alu_op_e (4-bit enum above).
  - br_funct3_e (BEQ, BNE, BLT, BGE, BLTU, BGEU).
  - XLEN constant.
- One natural sub-module, branch_compare, for the comparator; the ALU case statement stays in the top.

Test Plan:
- ADD 0x7FFFFFFF + 0x00000001 → result 0x80000000; SUB 0 - 1 → 0xFFFFFFFF; PASSB in2 = 0x12345000 → 0x12345000.
- Shifts with in1 = 0x80000000, in2 = 0x0000003F (shift amount 31):
  - SRA → 0xFFFFFFFF.
  - SRL → 0x00000001.
  - SLL with in1 = 1, in2 = 0x21 → 0x00000002.
- SLT and SLTU with in1 = 0xFFFFFFFF, in2 = 0 → SLT = 1, SLTU = 0; AND/OR/XOR on 0xF0F0F0F0 and 0x0FF00FF0 → 0x00F000F0 / 0xFFF0FFF0 / 0xFF00FF00.
- Compare cmp_in1 = 0xFFFFFFFE, cmp_in2 = 1:
  - BLT = 1, BGE = 0, BLTU = 0, BGEU = 1, BEQ = 0, BNE = 1.
  - Equal operands 5,5 → BEQ = 1, BGE = 1.
  - funct3 = 010 → cond = 0.
- Registered stage: valid_in = 1 with ADD 3 + 4 → next edge result_q = 7, valid_q = 1; valid_in = 0 with new operands → result_q stays 7, valid_q = 0.
- Assert rst mid-cycle, between edges, while result_q = 7 → result_q, cond_q and valid_q go to 0 before the next edge; combinational result still tracks its inputs.
